// File: rtl/kypd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : kypd_pkg
// Brief    : Shared state encoding, idle column and key map for the keypad scanner
// Revision : 1.0
// ============================================================================
package kypd_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kypd_state_e;

    localparam logic [3:0] COL_IDLE = 4'b1110;

    // Entry {row, col} lives at bits [4*(row*4+col) +: 4].
    localparam logic [63:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        case (col)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd3;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kypd_decode.sv
`default_nettype none
// ============================================================================
// Module   : kypd_decode
// Brief    : Combinational (row, column) to hex key code lookup
// Revision : 1.0
// ============================================================================
module kypd_decode
    import kypd_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic [3:0] key_code
);

    always_comb begin
        key_code = KEY_MAP[{row_idx, col_idx, 2'b00} +: 4];
    end

endmodule
`default_nettype wire

// File: rtl/kypd_scan.sv
`default_nettype none
// ============================================================================
// Module   : kypd_scan
// Brief    : 4x4 keypad column scanner with row sync, debounce and key strobe
// Revision : 1.0
// ============================================================================
module kypd_scan
    import kypd_pkg::*;
#(
    parameter int COL_BITS = 14,
    parameter int DB_BITS  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    kypd_state_e         state_q, state_d;
    logic [3:0]          sync1_q, row_s_q;
    logic [COL_BITS-1:0] dwell_q, dwell_d;
    logic [DB_BITS-1:0]  db_q, db_d;
    logic [3:0]          col_q, col_d;
    logic [1:0]          r_q, r_d, c_q, c_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_down_q, key_down_d;
    logic [3:0]          map_code;
    logic [3:0]          col_next;
    logic                dwell_tc, db_tc, rows_idle;

    kypd_decode u_decode (
        .row_idx  (r_q),
        .col_idx  (c_q),
        .key_code (map_code)
    );

    assign col_next  = {col_q[2:0], col_q[3]};
    assign dwell_tc  = &dwell_q;
    assign db_tc     = &db_q;
    assign rows_idle = (row_s_q == 4'b1111);

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        db_d        = db_q;
        col_d       = col_q;
        r_d         = r_q;
        c_d         = c_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        case (state_q)
            ST_SCAN: begin
                dwell_d = dwell_q + COL_BITS'(1);
                if (dwell_tc) begin
                    if (rows_idle) begin
                        col_d = col_next;
                    end else begin
                        r_d     = lowest_low(row_s_q);
                        c_d     = col_index(col_q);
                        db_d    = '0;
                        dwell_d = '0;
                        state_d = ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (row_s_q[r_q]) begin
                    // Bounce: abandon this key and move on to the next column.
                    db_d    = '0;
                    col_d   = col_next;
                    dwell_d = '0;
                    state_d = ST_SCAN;
                end else begin
                    db_d = db_q + DB_BITS'(1);
                    if (db_tc) begin
                        key_valid_d = 1'b1;
                        key_code_d  = map_code;
                        key_down_d  = 1'b1;
                        state_d     = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (rows_idle) begin
                    db_d    = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!rows_idle) begin
                    db_d    = '0;
                    state_d = ST_HELD;
                end else begin
                    db_d = db_q + DB_BITS'(1);
                    if (db_tc) begin
                        key_down_d = 1'b0;
                        col_d      = col_next;
                        dwell_d    = '0;
                        state_d    = ST_SCAN;
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            sync1_q     <= 4'b1111;
            row_s_q     <= 4'b1111;
            dwell_q     <= '0;
            db_q        <= '0;
            col_q       <= COL_IDLE;
            r_q         <= 2'd0;
            c_q         <= 2'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= row;
            row_s_q     <= sync1_q;
            dwell_q     <= dwell_d;
            db_q        <= db_d;
            col_q       <= col_d;
            r_q         <= r_d;
            c_q         <= c_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule
`default_nettype wire

// File: tb/tb_kypd_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_kypd_scan
// Brief    : Self-checking bench for kypd_scan with a keypad and reference model
// Revision : 1.0
// ============================================================================
module tb_kypd_scan;

    localparam int COL_BITS = 2;
    localparam int DB_BITS  = 3;
    localparam int DWELL    = 1 << COL_BITS;
    localparam int DBN      = 1 << DB_BITS;

    localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed = '0;
    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;

    int key_val [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    kypd_scan #(.COL_BITS(COL_BITS), .DB_BITS(DB_BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Keypad: a row reads low when any pressed key on it sits in the driven column.
    always_comb begin
        row = 4'b1111;
        for (int i = 0; i < 4; i++) row[i] = ~|(pressed[i*4 +: 4] & ~col);
    end

    // Reference model: cycle view of the scan/debounce rules using integer timers.
    int         m_mode, m_dwell, m_db, m_c, m_r;
    logic [3:0] m_pipe [2];
    logic [3:0] m_code;
    bit         m_valid, m_down;

    always @(posedge clk) begin
        logic [3:0] rs;
        rs = m_pipe[1];
        if (reset) begin
            m_mode = M_SCAN; m_dwell = 0; m_db = 0; m_c = 0; m_r = 0;
            m_pipe[0] = 4'hF; m_pipe[1] = 4'hF;
            m_code = 4'h0; m_valid = 1'b0; m_down = 1'b0;
        end else begin
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = row;
            m_valid = 1'b0;
            case (m_mode)
                M_SCAN: begin
                    if (m_dwell == DWELL - 1) begin
                        m_dwell = 0;
                        if (rs == 4'hF) m_c = (m_c + 1) % 4;
                        else begin
                            for (int i = 3; i >= 0; i--) if (!rs[i]) m_r = i;
                            m_db = 0;
                            m_mode = M_DEB;
                        end
                    end else m_dwell++;
                end
                M_DEB: begin
                    if (rs[m_r]) begin
                        m_db = 0; m_c = (m_c + 1) % 4; m_dwell = 0; m_mode = M_SCAN;
                    end else if (m_db == DBN - 1) begin
                        m_mode = M_HELD; m_valid = 1'b1; m_down = 1'b1;
                        m_code = 4'(key_val[m_r*4 + m_c]);
                    end else m_db++;
                end
                M_HELD: if (rs == 4'hF) begin m_mode = M_REL; m_db = 0; end
                default: begin
                    if (rs != 4'hF) begin
                        m_db = 0; m_mode = M_HELD;
                    end else if (m_db == DBN - 1) begin
                        m_down = 1'b0; m_c = (m_c + 1) % 4; m_dwell = 0; m_mode = M_SCAN;
                    end else m_db++;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic [3:0] ec;
        if (mon_en) begin
            ec = 4'hF;
            ec[m_c] = 1'b0;
            vectors += 4;
            if (col !== ec) begin
                miscompares++;
                $display("FAIL mon_col t=%0t got=%b exp=%b", $time, col, ec);
            end
            if (key_valid !== m_valid) begin
                miscompares++;
                $display("FAIL mon_key_valid t=%0t got=%b exp=%b", $time, key_valid, m_valid);
            end
            if (key_down !== m_down) begin
                miscompares++;
                $display("FAIL mon_key_down t=%0t got=%b exp=%b", $time, key_down, m_down);
            end
            if (key_code !== m_code) begin
                miscompares++;
                $display("FAIL mon_key_code t=%0t got=%h exp=%h", $time, key_code, m_code);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] ec;
        reset = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        vectors++;
        if (col !== 4'b1110) begin miscompares++; $display("FAIL reset_col got=%b exp=1110", col); end
        vectors++;
        if (key_code !== 4'h0) begin miscompares++; $display("FAIL reset_code got=%h exp=0", key_code); end
        vectors++;
        if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        vectors++;
        if (key_down !== 1'b0) begin miscompares++; $display("FAIL reset_down got=%b exp=0", key_down); end
        reset = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            ec = 4'hF;
            ec[(n / DWELL) % 4] = 1'b0;
            vectors++;
            if (col !== ec) begin miscompares++; $display("FAIL idle_col n=%0d got=%b exp=%b", n, col, ec); end
            vectors++;
            if (key_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid n=%0d got=%b exp=0", n, key_valid); end
        end
    endtask

    task automatic test_press_5();
        int nvalid = 0;
        pressed[1*4 + 1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (key_valid === 1'b1) begin
                nvalid++;
                vectors++;
                if (key_code !== 4'h5) begin miscompares++; $display("FAIL press5_code got=%h exp=5", key_code); end
            end
        end
        vectors++;
        if (nvalid != 1) begin miscompares++; $display("FAIL press5_strobes got=%0d exp=1", nvalid); end
        vectors++;
        if (key_down !== 1'b1) begin miscompares++; $display("FAIL press5_down got=%b exp=1", key_down); end
        pressed = '0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 10) begin
                vectors++;
                if (key_down !== 1'b1) begin miscompares++; $display("FAIL rel5_early got=%b exp=1", key_down); end
            end
        end
        vectors++;
        if (key_down !== 1'b0) begin miscompares++; $display("FAIL rel5_down got=%b exp=0", key_down); end
        vectors++;
        if (col !== 4'b1011) begin miscompares++; $display("FAIL rel5_col got=%b exp=1011", col); end
    endtask

    task automatic test_bounce_d();
        int nvalid = 0;
        logic [3:0] seen = 4'h0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) pressed[15] = ~pressed[15];
            tick();
            if (key_valid === 1'b1) nvalid++;
        end
        pressed = '0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (key_valid === 1'b1) nvalid++;
            for (int b = 0; b < 4; b++) if (col[b] === 1'b0) seen[b] = 1'b1;
        end
        vectors++;
        if (nvalid != 0) begin miscompares++; $display("FAIL bounce_strobes got=%0d exp=0", nvalid); end
        vectors++;
        if (key_code !== 4'h5) begin miscompares++; $display("FAIL bounce_code got=%h exp=5", key_code); end
        vectors++;
        if (seen !== 4'hF) begin miscompares++; $display("FAIL bounce_rotate got=%b exp=1111", seen); end
    endtask

    task automatic test_multi_1_7();
        int nvalid = 0;
        int n = 0;
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (key_valid === 1'b1) begin
                nvalid++;
                vectors++;
                if (key_code !== 4'h1) begin miscompares++; $display("FAIL multi_code got=%h exp=1", key_code); end
            end
        end
        vectors++;
        if (nvalid != 1) begin miscompares++; $display("FAIL multi_strobes got=%0d exp=1", nvalid); end
        pressed[0] = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (key_valid === 1'b1) nvalid++;
        end
        vectors++;
        if (nvalid != 0) begin miscompares++; $display("FAIL multi_restrobe got=%0d exp=0", nvalid); end
        vectors++;
        if (key_down !== 1'b1) begin miscompares++; $display("FAIL multi_down got=%b exp=1", key_down); end
        pressed[8] = 1'b0;
        while (key_down === 1'b1 && n < 20) begin tick(); n++; end
        vectors++;
        if (key_down !== 1'b0) begin miscompares++; $display("FAIL multi_release got=%b exp=0", key_down); end
    endtask

    task automatic test_reset_in_held();
        int n = 0;
        pressed[3*4 + 1] = 1'b1;
        while (key_valid !== 1'b1 && n < 60) begin tick(); n++; end
        vectors++;
        if (key_valid !== 1'b1) begin miscompares++; $display("FAIL rsth_first got=%b exp=1", key_valid); end
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (col !== 4'b1110) begin miscompares++; $display("FAIL rsth_col got=%b exp=1110", col); end
        vectors++;
        if (key_code !== 4'h0) begin miscompares++; $display("FAIL rsth_code got=%h exp=0", key_code); end
        vectors++;
        if (key_down !== 1'b0) begin miscompares++; $display("FAIL rsth_down got=%b exp=0", key_down); end
        vectors++;
        if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rsth_valid got=%b exp=0", key_valid); end
        n = 0;
        while (key_valid !== 1'b1 && n < 80) begin tick(); n++; end
        vectors++;
        if (key_valid !== 1'b1) begin miscompares++; $display("FAIL rsth_restrobe got=%b exp=1", key_valid); end
        vectors++;
        if (key_code !== 4'hF) begin miscompares++; $display("FAIL rsth_code2 got=%h exp=f", key_code); end
        pressed = '0;
        n = 0;
        while (key_down === 1'b1 && n < 20) begin tick(); n++; end
        vectors++;
        if (key_down !== 1'b0) begin miscompares++; $display("FAIL rsth_release got=%b exp=0", key_down); end
    endtask

    task automatic test_release_glitch();
        int k = $urandom_range(0, 15);
        int n = 0;
        pressed[k] = 1'b1;
        while (key_valid !== 1'b1 && n < 60) begin tick(); n++; end
        vectors++;
        if (key_valid !== 1'b1) begin miscompares++; $display("FAIL glitch_strobe key=%0d got=%b exp=1", k, key_valid); end
        tick(); tick();
        pressed = '0;
        for (int i = 0; i < 4; i++) tick();
        pressed[k] = 1'b1;
        tick();
        pressed = '0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            vectors++;
            if (key_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid i=%0d got=%b exp=0", i, key_valid); end
            if (i < 11) begin
                vectors++;
                if (key_down !== 1'b1) begin miscompares++; $display("FAIL glitch_hold i=%0d got=%b exp=1", i, key_down); end
            end
        end
        vectors++;
        if (key_down !== 1'b0) begin miscompares++; $display("FAIL glitch_release got=%b exp=0", key_down); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int k = $urandom_range(0, 15);
            int hold = $urandom_range(45, 70);
            int nvalid = 0;
            pressed[k] = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (key_valid === 1'b1) begin
                    nvalid++;
                    vectors++;
                    if (key_code !== 4'(key_val[k])) begin
                        miscompares++;
                        $display("FAIL rand_code key=%0d got=%h exp=%h", k, key_code, 4'(key_val[k]));
                    end
                end
            end
            vectors++;
            if (nvalid != 1) begin miscompares++; $display("FAIL rand_strobes key=%0d got=%0d exp=1", k, nvalid); end
            pressed = '0;
            for (int i = 0; i < 25; i++) tick();
            vectors++;
            if (key_down !== 1'b0) begin miscompares++; $display("FAIL rand_release key=%0d got=%b exp=0", k, key_down); end
        end
    endtask

    initial begin
        test_reset();
        test_press_5();
        test_bounce_d();
        test_multi_1_7();
        test_reset_in_held();
        test_release_glitch();
        test_random();
        tick();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
